// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch queue.
//   FQ_DEPTH    : default queue depth
//   FQ_RESET_PC : default first fetch address
//   fq_state_e  : fetch FSM states
//   fq_entry_t  : one queued instruction with the PC it was fetched from
package fetch_pkg;
  localparam int          FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// Small synchronous FIFO of fq_entry_t with a combinational head read.
//   clk, rst         : clock, async active-high reset
//   push, push_data  : write one entry at the tail
//   pop              : remove the head (ignored when empty)
//   flush            : empty the queue; wins over push and pop
//   head_valid, head : head entry, zeroed when empty
//   count            : occupancy, 0..DEPTH
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            pop_ok;

  assign head_valid = (count != '0);
  assign pop_ok     = pop & head_valid;
  assign head       = head_valid ? mem[rd_ptr] : '0;

  // Pointers wrap naturally (DEPTH is a power of two); fullness comes from count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  // Storage carries no reset: head is masked by head_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Upstream issue throttling must never let a write land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end feeding the IF/ID register.
// Issues sequential fetches to a 1-cycle synchronous instruction memory,
// queues returned instructions with their PC, and restarts at a redirect.
//   i_clk, i_rst                  : clock, async active-high reset
//   i_redirect, i_redirect_pc     : execute-stage redirect and its target
//   i_halt                        : stop issuing; queue keeps draining
//   o_imem_addr, o_imem_req       : memory address / read issued this cycle
//   i_imem_data                   : read data, one cycle after o_imem_req
//   o_valid, o_instr, o_pc, o_pc_4: queue head towards decode
//   i_ready                       : decode takes the head this cycle
//   o_count                       : queue occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  input  logic                   i_halt,
  output logic [31:0]            o_imem_addr,
  output logic                   o_imem_req,
  input  logic [31:0]            i_imem_data,
  output logic                   o_valid,
  output logic [31:0]            o_instr,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_pc_4,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e   state, state_nxt;
  logic [31:0] fetch_pc, req_pc;
  logic        inflight;
  logic        push;
  fq_entry_t   head;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   if (i_halt)  state_nxt = S_HALT;
      S_HALT:  if (!i_halt) state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  // ---------------- issue ----------------
  // Counting the in-flight read as occupied guarantees its response a slot.
  assign o_imem_req  = (state == S_RUN) && !i_redirect &&
                       ((o_count + CW'(inflight)) < CW'(DEPTH));
  assign o_imem_addr = fetch_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_imem_req;
      if (o_imem_req) req_pc <= fetch_pc;
      if (i_redirect)      fetch_pc <= i_redirect_pc & ~32'h3;
      else if (o_imem_req) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // A response arriving in a redirect cycle belongs to the dead path.
  assign push = inflight && !i_redirect;

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (push),
    .push_data  ('{pc: req_pc, instr: i_imem_data}),
    .pop        (i_ready),
    .flush      (i_redirect),
    .head_valid (o_valid),
    .head       (head),
    .count      (o_count)
  );

  assign o_instr = head.instr;
  assign o_pc    = head.pc;
  assign o_pc_4  = o_valid ? head.pc + 32'd4 : 32'd0;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        halt = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] imem_addr, imem_data, instr, pc, pc_4;
  logic        imem_req, valid;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .i_redirect(redir), .i_redirect_pc(redir_pc),
    .i_halt(halt), .o_imem_addr(imem_addr), .o_imem_req(imem_req),
    .i_imem_data(imem_data), .o_valid(valid), .o_instr(instr), .o_pc(pc),
    .o_pc_4(pc_4), .i_ready(ready), .o_count(count)
  );

  always #5 clk = ~clk;

  // Memory model: word at addr holds addr>>2; junk when no read was issued.
  always @(posedge clk) imem_data <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

  // Scoreboard: PCs requested since the last flush, in order.
  logic [31:0] exp_q [$];
  logic [31:0] exp_fetch = 32'h0;
  logic        prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Book-keeping for the cycle about to end (inputs/outputs stable).
  task automatic sb_update();
    logic [31:0] e;
    if (!rst) begin
      if (redir) begin
        chk("redir_noreq", {31'b0, imem_req}, 32'd0);
        exp_q.delete();
        exp_fetch = redir_pc & ~32'h3;
      end else begin
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected_pop: got pc %08h expected none", pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e);
            chk("sb_instr", instr, e >> 2);
            chk("sb_pc4", pc_4, e + 32'd4);
          end
        end
        if (imem_req) begin
          chk("sb_addr", imem_addr, exp_fetch);
          exp_q.push_back(exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
    prev_req = imem_req;
  endtask

  task automatic cyc(input logic r_rst, input logic r_ready, input logic r_halt,
                     input logic r_redir, input logic [31:0] r_pc);
    sb_update();
    @(negedge clk);
    rst = r_rst; ready = r_ready; halt = r_halt; redir = r_redir; redir_pc = r_pc;
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
  } vec_t;
  vec_t tbl [18];

  initial begin
    // Cycle-by-cycle from reset release: fill, stall for 10 cycles, drain.
    tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 3'd0};
    tbl[3] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 3'd1};
    tbl[4] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0, 3'd2};
    tbl[5] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 3'd3};
    for (int i = 6; i <= 12; i++) tbl[i] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 3'd4};
    tbl[13] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4};
    tbl[14] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 3'd3};
    tbl[15] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 3'd2};
    tbl[16] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd2};
    tbl[17] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2};

    // Reset state
    cyc(1, 1, 0, 0, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pc4", pc_4, 0);
    chk("rst_count", {29'b0, count}, 0);

    foreach (tbl[i]) begin
      cyc(0, tbl[i].ready, 0, 0, 0);
      chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
      chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].exp_valid});
      chk($sformatf("t%0d_pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("t%0d_pc4", i), pc_4, tbl[i].exp_valid ? tbl[i].exp_pc + 32'd4 : 32'd0);
      chk($sformatf("t%0d_instr", i), instr, tbl[i].exp_valid ? tbl[i].exp_pc >> 2 : 32'd0);
      chk($sformatf("t%0d_count", i), {29'b0, count}, {29'b0, tbl[i].exp_cnt});
    end

    // Redirect with 2 queued and 1 in flight, decode stalled
    cyc(0, 0, 0, 1, 32'h103);
    chk("a_pre_count", {29'b0, count}, 2);
    chk("a_pre_inflight", {31'b0, prev_req}, 1);
    cyc(0, 0, 0, 0, 0);
    chk("a_valid", {31'b0, valid}, 0);
    chk("a_count", {29'b0, count}, 0);
    chk("a_req", {31'b0, imem_req}, 1);
    chk("a_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 0, 0);
    chk("a_valid2", {31'b0, valid}, 0);
    cyc(0, 0, 0, 0, 0);
    chk("a_valid3", {31'b0, valid}, 1);
    chk("a_first_pc", pc, 32'h100);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);

    // Redirect + pop + response arrival together
    cyc(0, 1, 0, 1, 32'h200);
    chk("b_pop_pending", {31'b0, valid}, 1);
    chk("b_resp_arriving", {31'b0, prev_req}, 1);
    cyc(0, 1, 0, 0, 0);
    chk("b_valid", {31'b0, valid}, 0);
    chk("b_count", {29'b0, count}, 0);
    chk("b_addr", imem_addr, 32'h200);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);

    // Halt with 3 queued, drain, resume
    cyc(0, 0, 0, 1, 32'h300);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("c_last_req", {31'b0, imem_req}, 1);
    cyc(0, 0, 1, 0, 0);
    chk("c_noreq0", {31'b0, imem_req}, 0);
    cyc(0, 0, 1, 0, 0);
    chk("c_noreq1", {31'b0, imem_req}, 0);
    chk("c_count3", {29'b0, count}, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, 0);
      chk($sformatf("c_drain_noreq%0d", i), {31'b0, imem_req}, 0);
    end
    chk("c_empty", {29'b0, count}, 0);
    cyc(0, 1, 0, 0, 0);
    chk("c_still_halted", {31'b0, imem_req}, 0);
    cyc(0, 1, 0, 0, 0);
    chk("c_resume_req", {31'b0, imem_req}, 1);
    chk("c_resume_addr", imem_addr, 32'h30C);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

    // PC wrap
    cyc(0, 1, 0, 1, 32'hFFFF_FFFE);
    cyc(0, 1, 0, 0, 0);
    chk("d_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 0);
    chk("d_req_wrap", {31'b0, imem_req}, 1);
    chk("d_addr_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

    // Reset mid-operation
    cyc(1, 1, 0, 0, 0);
    chk("e_valid", {31'b0, valid}, 0);
    chk("e_count", {29'b0, count}, 0);
    chk("e_req", {31'b0, imem_req}, 0);
    chk("e_addr", imem_addr, 32'h0);
    exp_q.delete();
    exp_fetch = 32'h0;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("e_boot_noreq", {31'b0, imem_req}, 0);
    cyc(0, 1, 0, 0, 0);
    chk("e_req0", {31'b0, imem_req}, 1);
    chk("e_addr0", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

    // Halt and drain everything still owed
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0);
    sb_update();
    chk("f_sb_empty", exp_q.size(), 0);
    chk("f_count", {29'b0, count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
